// File: rtl/display_scan_mux.sv
// Four-digit display scanner: steps the digit select, shows a frame-consistent
// shadow copy of the BCD digits, and generates the set-mode blink blank.
module display_scan_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_in,
    input  logic        load,
    input  logic        blink_en,
    input  logic [3:0]  blink_mask,
    output logic [1:0]  en,
    output logic [3:0]  num,
    output logic        blank,
    output logic        scan_tick
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt_r;
    logic [BW-1:0] blink_cnt_r;
    logic          blink_phase_r;
    logic [1:0]    en_r;
    logic [15:0]   shadow_r;
    logic [15:0]   staging_r;
    logic          pending_r;
    logic          dwell_last_s;
    logic          frame_wrap_s;

    // Dwell end and frame end decode
    always_comb begin
        dwell_last_s = (refresh_cnt_r == REFRESH_MAX);
        frame_wrap_s = dwell_last_s && (en_r == 2'd3);
    end

    // Refresh counter and digit select
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt_r <= '0;
            en_r          <= 2'd0;
        end else if (dwell_last_s) begin
            refresh_cnt_r <= '0;
            en_r          <= en_r + 2'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + RW'(1);
            en_r          <= en_r;
        end
    end

    // Staging/shadow load path; a load on the wrap edge bypasses staging so
    // the new value appears in the very next frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            staging_r <= 16'h0000;
            shadow_r  <= 16'h0000;
            pending_r <= 1'b0;
        end else if (load) begin
            staging_r <= digits_in;
            if (frame_wrap_s) begin
                shadow_r  <= digits_in;
                pending_r <= 1'b0;
            end else begin
                shadow_r  <= shadow_r;
                pending_r <= 1'b1;
            end
        end else if (frame_wrap_s && pending_r) begin
            staging_r <= staging_r;
            shadow_r  <= staging_r;
            pending_r <= 1'b0;
        end else begin
            staging_r <= staging_r;
            shadow_r  <= shadow_r;
            pending_r <= pending_r;
        end
    end

    // Blink timebase; held at zero while disabled so re-enable starts visible
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (blink_cnt_r == BLINK_MAX) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + BW'(1);
            blink_phase_r <= blink_phase_r;
        end
    end

    // Selected digit value, tick and blank
    always_comb begin
        num = 4'h0;
        case (en_r)
            2'd0:    num = shadow_r[3:0];
            2'd1:    num = shadow_r[7:4];
            2'd2:    num = shadow_r[11:8];
            2'd3:    num = shadow_r[15:12];
            default: num = 4'h0;
        endcase
        en        = en_r;
        scan_tick = dwell_last_s;
        blank     = blink_en & blink_phase_r & blink_mask[en_r];
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with REFRESH_DIV=4, BLINK_DIV=8.
module tb_display_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        load;
    logic        blink_en;
    logic [3:0]  blink_mask;
    logic [1:0]  en;
    logic [3:0]  num;
    logic        blank;
    logic        scan_tick;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [15:0] shadow_m = 16'h0000;
    logic [1:0]  e;
    logic [3:0]  n;
    logic        t;
    logic        b;

    display_scan_mux #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
        .blink_en(blink_en), .blink_mask(blink_mask), .en(en), .num(num),
        .blank(blank), .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; digits_in = 16'h0000;
        blink_en = 1'b0; blink_mask = 4'b0000;
        step();
        step();
        checks++;
        if ({en, num, blank, scan_tick} !== {2'd0, 4'h0, 1'b0, 1'b0}) begin
            $display("FAIL reset got en=%0d num=%h blank=%b tick=%b exp 0 0 0 0", en, num, blank, scan_tick);
            errors++;
        end
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 20; i++) begin
            e = 2'(cyc / 4); n = shadow_m[int'(e)*4 +: 4]; t = (cyc % 4 == 3); b = 1'b0;
            checks++;
            if ({en, num, blank, scan_tick} !== {e, n, b, t}) begin
                $display("FAIL scan cyc=%0d got en=%0d num=%h blank=%b tick=%b exp en=%0d num=%h blank=%b tick=%b",
                         cyc, en, num, blank, scan_tick, e, n, b, t);
                errors++;
            end
            step();
        end
    endtask

    task automatic test_load();
        digits_in = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        while (cyc < 48) begin
            if (cyc == 32) shadow_m = 16'h1234;
            e = 2'(cyc / 4); n = shadow_m[int'(e)*4 +: 4]; t = (cyc % 4 == 3); b = 1'b0;
            checks++;
            if ({en, num, blank, scan_tick} !== {e, n, b, t}) begin
                $display("FAIL load cyc=%0d got en=%0d num=%h tick=%b exp en=%0d num=%h tick=%b",
                         cyc, en, num, scan_tick, e, n, t);
                errors++;
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        while (cyc < 80) begin
            load = 1'b0;
            if (cyc == 48) begin digits_in = 16'h1234; load = 1'b1; end
            if (cyc == 53) begin digits_in = 16'h5678; load = 1'b1; end
            if (cyc == 64) shadow_m = 16'h5678;
            e = 2'(cyc / 4); n = shadow_m[int'(e)*4 +: 4]; t = (cyc % 4 == 3); b = 1'b0;
            checks++;
            if ({en, num, blank, scan_tick} !== {e, n, b, t}) begin
                $display("FAIL back_to_back cyc=%0d got en=%0d num=%h exp en=%0d num=%h", cyc, en, num, e, n);
                errors++;
            end
            step();
        end
        load = 1'b0;
    endtask

    task automatic test_wrap_load();
        while (cyc < 112) begin
            load = 1'b0;
            if (cyc == 95) begin digits_in = 16'h0959; load = 1'b1; end
            if (cyc == 96) shadow_m = 16'h0959;
            e = 2'(cyc / 4); n = shadow_m[int'(e)*4 +: 4]; t = (cyc % 4 == 3); b = 1'b0;
            checks++;
            if ({en, num, blank, scan_tick} !== {e, n, b, t}) begin
                $display("FAIL wrap_load cyc=%0d got en=%0d num=%h exp en=%0d num=%h", cyc, en, num, e, n);
                errors++;
            end
            step();
        end
        load = 1'b0;
    endtask

    task automatic test_blink();
        // Reload 1234 so it is on screen from cycle 128
        while (cyc < 132) begin
            load = (cyc == 112);
            digits_in = 16'h1234;
            if (cyc == 128) shadow_m = 16'h1234;
            step();
        end
        load = 1'b0;
        blink_en = 1'b1; blink_mask = 4'b1100;
        #1;
        for (int k = 0; k < 10; k++) begin
            e = 2'(cyc / 4); n = shadow_m[int'(e)*4 +: 4];
            b = (k >= 8) && blink_mask[e];
            checks++;
            if ({en, num, blank} !== {e, n, b}) begin
                $display("FAIL blink k=%0d got en=%0d num=%h blank=%b exp en=%0d num=%h blank=%b",
                         k, en, num, blank, e, n, b);
                errors++;
            end
            step();
        end
        blink_en = 1'b0;
        #1;
        while (cyc < 152) begin
            checks++;
            if ({en, blank} !== {2'(cyc / 4), 1'b0}) begin
                $display("FAIL blink_off cyc=%0d got en=%0d blank=%b exp blank=0", cyc, en, blank);
                errors++;
            end
            step();
        end
        blink_en = 1'b1;
        #1;
        for (int j = 0; j < 8; j++) begin
            e = 2'(cyc / 4);
            checks++;
            if ({en, blank} !== {e, 1'b0}) begin
                $display("FAIL blink_restart j=%0d got en=%0d blank=%b exp en=%0d blank=0", j, en, blank, e);
                errors++;
            end
            step();
        end
        blink_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        while (cyc < 168) begin
            load = (cyc == 160);
            digits_in = 16'h9999;
            step();
        end
        load = 1'b0;
        checks++;
        if ({en, num} !== {2'd2, 4'h2}) begin
            $display("FAIL pre_reset got en=%0d num=%h exp en=2 num=2", en, num);
            errors++;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cyc = 0;
        shadow_m = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            e = 2'(cyc / 4); n = 4'h0; t = (cyc % 4 == 3); b = 1'b0;
            checks++;
            if ({en, num, blank, scan_tick} !== {e, n, b, t}) begin
                $display("FAIL reset_mid cyc=%0d got en=%0d num=%h blank=%b tick=%b exp en=%0d num=0 blank=0 tick=%b",
                         cyc, en, num, blank, scan_tick, e, t);
                errors++;
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_wrap_load();
        test_blink();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
